// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and its lane aligner:
// funct3 encodings, the responder state type and request-check helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Stores only know B/H/W; loads additionally accept the unsigned forms.
    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        logic bad_s;
        bad_s = 1'b0;
        if (write) begin
            case (f3)
                F3_B, F3_H, F3_W: bad_s = 1'b0;
                default:          bad_s = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b011, 3'b110, 3'b111: bad_s = 1'b1;
                default:                bad_s = 1'b0;
            endcase
        end
        return bad_s;
    endfunction

    // Halves need even addresses, words need 4-byte alignment.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis_s;
        mis_s = 1'b0;
        case (f3)
            F3_H, F3_HU: mis_s = addr_lo[0];
            F3_W:        mis_s = (addr_lo != 2'b00);
            default:     mis_s = 1'b0;
        endcase
        return mis_s;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between a 32-bit memory word and the
// right-aligned data seen by a load/store unit.
module mem_lane_align (
    input  logic [31:0] load_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_wdata,
    output logic [31:0] load_data,
    output logic [3:0]  store_be,
    output logic [31:0] store_data
);
    import mem_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load path: pick the addressed byte/half and extend it to 32 bits.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = load_word[7:0];
            2'd1:    byte_s = load_word[15:8];
            2'd2:    byte_s = load_word[23:16];
            2'd3:    byte_s = load_word[31:24];
            default: byte_s = load_word[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = load_word[31:16];
        end else begin
            half_s = load_word[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = load_word;
            F3_BU:   load_data = {24'h00_0000, byte_s};
            F3_HU:   load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store path: replicate the data across lanes and enable only the target lanes.
    always_comb begin
        store_be   = 4'b0000;
        store_data = 32'h0000_0000;
        case (funct3)
            F3_B: begin
                store_be   = 4'b0001 << addr_lo;
                store_data = {4{store_wdata[7:0]}};
            end
            F3_H: begin
                if (addr_lo[1]) begin
                    store_be = 4'b1100;
                end else begin
                    store_be = 4'b0011;
                end
                store_data = {2{store_wdata[15:0]}};
            end
            F3_W: begin
                store_be   = 4'b1111;
                store_data = store_wdata;
            end
            default: begin
                store_be   = 4'b0000;
                store_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one load/store at a time,
// waits WAIT_CYCLES, performs the access and returns a registered response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    import mem_pkg::*;

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic        NO_WAIT    = (WAIT_CYCLES == 32'd0);

    state_e      state_r;
    logic [3:0]  cnt_r;
    logic        lat_write_r;
    logic [31:0] lat_addr_r;
    logic [2:0]  lat_f3_r;
    logic [31:0] lat_wdata_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic             accept_s;
    logic             op_write_s;
    logic [31:0]      op_addr_s;
    logic [2:0]       op_f3_s;
    logic [31:0]      op_wdata_s;
    logic             op_edge_s;
    logic [31:0]      off_s;
    logic [IDX_W-1:0] idx_s;
    logic             err_s;
    logic [31:0]      word_s;
    logic [31:0]      load_data_s;
    logic [3:0]       store_be_s;
    logic [31:0]      store_data_s;
    logic [31:0]      result_s;
    logic             mem_we_s;

    assign accept_s = req_valid & req_ready;

    // Operand source: live request when a zero-wait access executes on the
    // accept edge itself, otherwise the latched request.
    always_comb begin
        if (state_r == IDLE) begin
            op_write_s = req_write;
            op_addr_s  = req_addr;
            op_f3_s    = req_funct3;
            op_wdata_s = req_wdata;
        end else begin
            op_write_s = lat_write_r;
            op_addr_s  = lat_addr_r;
            op_f3_s    = lat_f3_r;
            op_wdata_s = lat_wdata_r;
        end
    end

    // The memory access happens on the edge that enters RESP.
    always_comb begin
        op_edge_s = 1'b0;
        case (state_r)
            IDLE:    op_edge_s = accept_s & NO_WAIT;
            WAIT:    op_edge_s = (cnt_r == 4'd1);
            default: op_edge_s = 1'b0;
        endcase
    end

    assign off_s  = op_addr_s - BASE_ADDR;
    assign idx_s  = off_s[IDX_W+1:2];
    assign err_s  = (op_addr_s < BASE_ADDR) | (off_s >= SPAN_BYTES)
                  | f3_illegal(op_write_s, op_f3_s)
                  | misaligned(op_f3_s, op_addr_s[1:0]);
    assign word_s = mem_r[idx_s];

    mem_lane_align u_align (
        .load_word   (word_s),
        .addr_lo     (op_addr_s[1:0]),
        .funct3      (op_f3_s),
        .store_wdata (op_wdata_s),
        .load_data   (load_data_s),
        .store_be    (store_be_s),
        .store_data  (store_data_s)
    );

    assign result_s = (err_s | op_write_s) ? 32'h0000_0000 : load_data_s;
    assign mem_we_s = op_edge_s & op_write_s & ~err_s;

    // Request/response FSM with wait counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            lat_write_r <= 1'b0;
            lat_addr_r  <= 32'h0000_0000;
            lat_f3_r    <= 3'b000;
            lat_wdata_r <= 32'h0000_0000;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0000_0000;
            resp_err    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept_s) begin
                        lat_write_r <= req_write;
                        lat_addr_r  <= req_addr;
                        lat_f3_r    <= req_funct3;
                        lat_wdata_r <= req_wdata;
                        req_ready   <= 1'b0;
                        if (NO_WAIT) begin
                            state_r    <= RESP;
                            resp_rdata <= result_s;
                            resp_err   <= err_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r    <= RESP;
                        cnt_r      <= 4'd0;
                        resp_rdata <= result_s;
                        resp_err   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Byte-enable write into the storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (resetn && mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (store_be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= store_data_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: one instance with two
// wait states, one with none, checked against a byte-array memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_ready;
    int          sel;

    logic        req_valid0, req_valid1, resp_ready0, resp_ready1;
    logic        req_ready0, req_ready1, resp_valid0, resp_valid1;
    logic [31:0] resp_rdata0, resp_rdata1;
    logic        resp_err0, resp_err1;
    logic        req_ready_m, resp_valid_m, resp_err_m;
    logic [31:0] resp_rdata_m;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  mm [0:1][0:1023];
    logic [31:0] got;

    always #5 clk = ~clk;

    assign req_valid0   = req_valid  && (sel == 0);
    assign req_valid1   = req_valid  && (sel == 1);
    assign resp_ready0  = resp_ready && (sel == 0);
    assign resp_ready1  = resp_ready && (sel == 1);
    assign req_ready_m  = (sel == 0) ? req_ready0  : req_ready1;
    assign resp_valid_m = (sel == 0) ? resp_valid0 : resp_valid1;
    assign resp_rdata_m = (sel == 0) ? resp_rdata0 : resp_rdata1;
    assign resp_err_m   = (sel == 0) ? resp_err0   : resp_err1;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (dut%0d): got %h expected %h at %0t", tag, sel, obs, exp, $time);
        end
    endtask

    // Reference memory: byte array, access size from funct3, little-endian.
    task automatic model_op(input int d, input logic w, input logic [31:0] a,
                            input logic [2:0] f3, input logic [31:0] wd,
                            output logic e, output logic [31:0] rd);
        int size;
        logic legal;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        e     = !legal || ((a % size) != 0) || (a >= 32'd1024);
        rd    = 32'h0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < size; i++) mm[d][a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(mm[d][a + i]) << (8 * i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
                rd = v;
            end
        end
    endtask

    // One full transaction on the selected DUT, holding resp_ready low for 'hold' cycles.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int hold, output logic [31:0] rd_obs);
        logic e_exp;
        logic [31:0] d_exp;
        logic [31:0] rd0;
        logic er0;
        int lat;
        int waited;
        waited = 0;
        while (!req_ready_m && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("idle_req_ready", 32'(req_ready_m), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
        model_op(sel, w, a, f3, wd, e_exp, d_exp);
        lat = 0;
        @(negedge clk);
        while (!resp_valid_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), (sel == 0) ? 32'd3 : 32'd1);
        check_eq("resp_err", 32'(resp_err_m), 32'(e_exp));
        check_eq("resp_rdata", resp_rdata_m, d_exp);
        check_eq("busy_req_ready", 32'(req_ready_m), 32'd0);
        rd_obs = resp_rdata_m;
        rd0    = resp_rdata_m;
        er0    = resp_err_m;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(resp_valid_m), 32'd1);
            check_eq("hold_rdata", resp_rdata_m, rd0);
            check_eq("hold_err", 32'(resp_err_m), 32'(er0));
            check_eq("hold_req_ready", 32'(req_ready_m), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check_eq("post_hs_valid", 32'(resp_valid_m), 32'd0);
        check_eq("post_hs_req_ready", 32'(req_ready_m), 32'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        w;
        int          r;
        sel        = 0;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready0", 32'(req_ready0), 32'd0);
        check_eq("rst_req_ready1", 32'(req_ready1), 32'd0);
        check_eq("rst_resp_valid0", 32'(resp_valid0), 32'd0);
        check_eq("rst_resp_valid1", 32'(resp_valid1), 32'd0);
        check_eq("rst_rdata0", resp_rdata0, 32'h0);
        check_eq("rst_err0", 32'(resp_err0), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("idle_after_rst0", 32'(req_ready0), 32'd1);
        check_eq("idle_after_rst1", 32'(req_ready1), 32'd1);

        // Preload the low 64 words of both memories.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i * 4), 3'b010, $urandom, 0, got);
        end

        // Directed sequence on both wait-state configurations.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            do_req(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 0, got);
            do_req(1'b0, 32'h10, 3'b010, 32'h0, 0, got);
            check_eq("lw_10", got, 32'hDEAD_BEEF);
            do_req(1'b0, 32'h13, 3'b000, 32'h0, 0, got);
            check_eq("lb_13", got, 32'hFFFF_FFDE);
            do_req(1'b0, 32'h13, 3'b100, 32'h0, 0, got);
            check_eq("lbu_13", got, 32'h0000_00DE);
            do_req(1'b0, 32'h10, 3'b001, 32'h0, 0, got);
            check_eq("lh_10", got, 32'hFFFF_BEEF);
            do_req(1'b0, 32'h12, 3'b101, 32'h0, 0, got);
            check_eq("lhu_12", got, 32'h0000_DEAD);
            do_req(1'b1, 32'h11, 3'b000, 32'h0000_00AA, 0, got);
            do_req(1'b0, 32'h10, 3'b010, 32'h0, 0, got);
            check_eq("lw_after_sb", got, 32'hDEAD_AAEF);
            do_req(1'b1, 32'h12, 3'b001, 32'h0000_1234, 0, got);
            do_req(1'b0, 32'h10, 3'b010, 32'h0, 0, got);
            check_eq("lw_after_sh", got, 32'h1234_AAEF);
            do_req(1'b0, 32'h12, 3'b010, 32'h0, 0, got);
            do_req(1'b1, 32'h400, 3'b010, 32'hFFFF_FFFF, 0, got);
            do_req(1'b1, 32'h10, 3'b011, 32'hFFFF_FFFF, 0, got);
            do_req(1'b0, 32'h10, 3'b011, 32'h0, 0, got);
            do_req(1'b0, 32'h10, 3'b010, 32'h0, 5, got);
            check_eq("lw_after_errs", got, 32'h1234_AAEF);
        end

        // Reset while a store is waiting: no write, no response.
        sel = 0;
        do_req(1'b1, 32'h20, 3'b010, 32'h0, 0, got);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_funct3 = 3'b010;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("midrst_resp_valid", 32'(resp_valid0), 32'd0);
            check_eq("midrst_req_ready", 32'(req_ready0), 32'd0);
        end
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("postrst_resp_valid", 32'(resp_valid0), 32'd0);
        end
        do_req(1'b0, 32'h20, 3'b010, 32'h0, 0, got);
        check_eq("lw_20_after_rst", got, 32'h0);

        // Randomized traffic across both instances.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 1);
            r   = $urandom_range(0, 99);
            if (r < 85)      a = 32'($urandom_range(0, 255));
            else if (r < 93) a = 32'h400 + 32'($urandom_range(0, 7));
            else             a = $urandom;
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            do_req(w, a, f3, $urandom, $urandom_range(0, 2), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
